// File: rtl/vtpg_pkg.sv
// Shared definitions for the video timing / test-pattern generator.
package vtpg_pkg;

    typedef enum logic [1:0] {
        MODE_RAMP  = 2'd0,
        MODE_SOLID = 2'd1,
        MODE_BARS  = 2'd2,
        MODE_CHECK = 2'd3
    } mode_e;

    // Bar index -> {ch0,ch1,ch2}: white, yellow, cyan, green, magenta, red, blue, black.
    function automatic logic [2:0] bar_bits(input logic [2:0] b);
        return {~b[1], ~b[2], ~b[0]};
    endfunction

endpackage

// File: rtl/vtpg_timing.sv
// x/y raster counters, range compares, registered strobes and the
// per-pixel counters (ramp value, colour-bar index) for the current pixel.
module vtpg_timing
    import vtpg_pkg::*;
#(
    parameter int H_BITS = 12,
    parameter int V_BITS = 12,
    parameter int PW     = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enable,
    input  logic [H_BITS-1:0] tH_END,
    input  logic [H_BITS-1:0] tHS_START,
    input  logic [H_BITS-1:0] tHS_END,
    input  logic [H_BITS-1:0] tHACT_START,
    input  logic [H_BITS-1:0] tHACT_END,
    input  logic [V_BITS-1:0] tV_END,
    input  logic [V_BITS-1:0] tVS_START,
    input  logic [V_BITS-1:0] tVS_END,
    input  logic [V_BITS-1:0] tVACT_START,
    input  logic [V_BITS-1:0] tVACT_END,
    input  logic [H_BITS-1:0] bar_w,
    output logic [H_BITS-1:0] x,
    output logic [V_BITS-1:0] y,
    output logic              at_origin,
    output logic              de_c,
    output logic [PW-1:0]     ramp_c,
    output logic [2:0]        bar_c,
    output logic              hs_act,
    output logic              vs_act,
    output logic              de,
    output logic              sof,
    output logic              eol
);

    logic [H_BITS-1:0] x_q, x_d, run_q, run_d, run_c, bw_eff;
    logic [V_BITS-1:0] y_q, y_d;
    logic [PW-1:0]     ramp_q, ramp_d;
    logic [2:0]        bar_q, bar_d;
    logic              hs_q, hs_d, vs_q, vs_d, de_q, de_d, sof_q, sof_d, eol_q, eol_d;
    logic              h_act, v_act, line_first, sof_c, eol_c;

    always_comb begin
        x_d = '0;
        y_d = '0;
        if (enable) begin
            if (x_q == tH_END) begin
                y_d = (y_q == tV_END) ? '0 : y_q + V_BITS'(1);
            end else begin
                x_d = x_q + H_BITS'(1);
                y_d = y_q;
            end
        end

        h_act      = (x_q >= tHACT_START) && (x_q < tHACT_END);
        v_act      = (y_q >= tVACT_START) && (y_q < tVACT_END);
        de_c       = h_act && v_act;
        line_first = de_c && (x_q == tHACT_START);
        sof_c      = line_first && (y_q == tVACT_START);
        eol_c      = de_c && (x_q == tHACT_END - H_BITS'(1));

        ramp_c = sof_c ? '0 : ramp_q;
        ramp_d = ramp_q;
        if (!enable)  ramp_d = '0;
        else if (de_c) ramp_d = ramp_c + PW'(1);

        // Bar run length restarts with each active line; bar_w==0 behaves as 1.
        bw_eff = (bar_w == '0) ? H_BITS'(1) : bar_w;
        run_c  = line_first ? '0 : run_q;
        bar_c  = line_first ? 3'd0 : bar_q;
        run_d  = run_q;
        bar_d  = bar_q;
        if (!enable) begin
            run_d = '0;
            bar_d = 3'd0;
        end else if (de_c) begin
            if (run_c + H_BITS'(1) == bw_eff) begin
                run_d = '0;
                bar_d = (bar_c == 3'd7) ? 3'd7 : bar_c + 3'd1;
            end else begin
                run_d = run_c + H_BITS'(1);
                bar_d = bar_c;
            end
        end

        hs_d  = enable && (x_q >= tHS_START) && (x_q < tHS_END);
        vs_d  = enable && (y_q >= tVS_START) && (y_q < tVS_END);
        de_d  = enable && de_c;
        sof_d = enable && sof_c;
        eol_d = enable && eol_c;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            x_q    <= '0;
            y_q    <= '0;
            ramp_q <= '0;
            run_q  <= '0;
            bar_q  <= 3'd0;
            hs_q   <= 1'b0;
            vs_q   <= 1'b0;
            de_q   <= 1'b0;
            sof_q  <= 1'b0;
            eol_q  <= 1'b0;
        end else begin
            x_q    <= x_d;
            y_q    <= y_d;
            ramp_q <= ramp_d;
            run_q  <= run_d;
            bar_q  <= bar_d;
            hs_q   <= hs_d;
            vs_q   <= vs_d;
            de_q   <= de_d;
            sof_q  <= sof_d;
            eol_q  <= eol_d;
        end
    end

    assign x         = x_q;
    assign y         = y_q;
    assign at_origin = (x_q == '0) && (y_q == '0);
    assign hs_act    = hs_q;
    assign vs_act    = vs_q;
    assign de        = de_q;
    assign sof       = sof_q;
    assign eol       = eol_q;

endmodule

// File: rtl/vtpg_pattern.sv
// Video timing + test-pattern generator top: frame-aligned config latch and
// a registered pattern stage that lines pix up with de.
module vtpg_pattern
    import vtpg_pkg::*;
#(
    parameter int H_BITS   = 12,
    parameter int V_BITS   = 12,
    parameter int PW       = 8,
    parameter int NCH      = 3,
    parameter int CHK_LOG2 = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enable,
    input  logic [1:0]        mode,
    input  logic [NCH*PW-1:0] solid,
    input  logic [H_BITS-1:0] bar_w,
    input  logic [H_BITS-1:0] tH_END,
    input  logic [H_BITS-1:0] tHS_START,
    input  logic [H_BITS-1:0] tHS_END,
    input  logic [H_BITS-1:0] tHACT_START,
    input  logic [H_BITS-1:0] tHACT_END,
    input  logic [V_BITS-1:0] tV_END,
    input  logic [V_BITS-1:0] tVS_START,
    input  logic [V_BITS-1:0] tVS_END,
    input  logic [V_BITS-1:0] tVACT_START,
    input  logic [V_BITS-1:0] tVACT_END,
    input  logic              pol_h,
    input  logic              pol_v,
    output logic              hs,
    output logic              vs,
    output logic              de,
    output logic              sof,
    output logic              eol,
    output logic [NCH*PW-1:0] pix
);

    logic [H_BITS-1:0]         x, ax, bar_w_q, bar_w_d;
    logic [V_BITS-1:0]         y, ay;
    logic                      at_origin, de_c, hs_act, vs_act;
    logic [PW-1:0]             ramp_c;
    logic [2:0]                bar_c, rgb;
    mode_e                     mode_q, mode_d;
    logic [NCH*PW-1:0]         solid_q, solid_d;
    logic [NCH-1:0][PW-1:0]    pix_q, pix_d;

    vtpg_timing #(.H_BITS(H_BITS), .V_BITS(V_BITS), .PW(PW)) u_timing (
        .clk         (clk),
        .rst         (rst),
        .enable      (enable),
        .tH_END      (tH_END),
        .tHS_START   (tHS_START),
        .tHS_END     (tHS_END),
        .tHACT_START (tHACT_START),
        .tHACT_END   (tHACT_END),
        .tV_END      (tV_END),
        .tVS_START   (tVS_START),
        .tVS_END     (tVS_END),
        .tVACT_START (tVACT_START),
        .tVACT_END   (tVACT_END),
        .bar_w       (bar_w_d),
        .x           (x),
        .y           (y),
        .at_origin   (at_origin),
        .de_c        (de_c),
        .ramp_c      (ramp_c),
        .bar_c       (bar_c),
        .hs_act      (hs_act),
        .vs_act      (vs_act),
        .de          (de),
        .sof         (sof),
        .eol         (eol)
    );

    always_comb begin
        // At (0,0) the live config applies, so the frame's first pixel already uses it.
        mode_d  = at_origin ? mode_e'(mode) : mode_q;
        solid_d = at_origin ? solid : solid_q;
        bar_w_d = at_origin ? bar_w : bar_w_q;

        ax  = x - tHACT_START;
        ay  = y - tVACT_START;
        rgb = bar_bits(bar_c);

        pix_d = '0;
        if (enable && de_c) begin
            case (mode_d)
                MODE_RAMP: begin
                    for (int c = 0; c < NCH; c++) pix_d[c] = ramp_c;
                end
                MODE_SOLID: pix_d = solid_d;
                MODE_BARS: begin
                    for (int c = 0; c < NCH; c++)
                        if (c < 3) pix_d[NCH-1-c] = {PW{rgb[2-c]}};
                end
                MODE_CHECK: begin
                    if (!(ax[CHK_LOG2] ^ ay[CHK_LOG2])) pix_d = '1;
                end
                default: pix_d = '0;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mode_q  <= MODE_RAMP;
            solid_q <= '0;
            bar_w_q <= '0;
            pix_q   <= '0;
        end else begin
            mode_q  <= mode_d;
            solid_q <= solid_d;
            bar_w_q <= bar_w_d;
            pix_q   <= pix_d;
        end
    end

    // Polarity is applied after the register so idle level follows pol_h/pol_v.
    assign hs  = hs_act ^ ~pol_h;
    assign vs  = vs_act ^ ~pol_v;
    assign pix = pix_q;

endmodule
